gc_poll_tx: RTL and testbench

Transmit side of the GameCube controller one-wire link: serialises the 24-bit poll command plus stop bit onto the shared data line (open-drain, drive-low only). It then raises `ready` for a fixed listen window so the button receiver on the same line counts and samples the controller's 64-bit response. It is an APB3 slave on the processor bus. Polling is either continuous at a programmable period or triggered by software.

---
 rtl/gc_pkg.sv | 25 ++
 rtl/gc_bit_tx.sv | 52 +++++
 rtl/gc_poll_tx.sv | 181 ++++++++++++++++++
 tb/tb_gc_poll_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gc_pkg.sv
// Shared constants for the GameCube poll transmitter: command word, bit-cell
// phase lengths, APB register offsets and the FSM state encoding.
package gc_pkg;

    localparam logic [23:0] POLL_CMD = 24'h400302;

    localparam int LOW0_US = 3;
    localparam int LOW1_US = 1;
    localparam int CELL_US = 4;
    localparam int STOP_US = 1;

    localparam logic [3:0]  ADDR_CTRL   = 4'h0;
    localparam logic [3:0]  ADDR_PERIOD = 4'h4;
    localparam logic [3:0]  ADDR_STATUS = 4'h8;

    localparam logic [15:0] PERIOD_RST  = 16'd16667;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_STOP,
        ST_LISTEN
    } gc_state_e;

endpackage

// File: rtl/gc_bit_tx.sv
// One bit cell (or the stop bit) on the open-drain line; line_low is registered
// and done pulses in the last cycle of the cell so the next cell can start seamlessly.
module gc_bit_tx
    import gc_pkg::*;
#(
    parameter int CLK_PER_US = 100
) (
    input  logic PCLK,
    input  logic PRESERN,
    input  logic start,
    input  logic bit_val,
    input  logic is_stop,
    output logic line_low,
    output logic done
);

    localparam logic [15:0] CELL_LAST = 16'(CELL_US * CLK_PER_US - 1);
    localparam logic [15:0] STOP_LAST = 16'(STOP_US * CLK_PER_US - 1);
    localparam logic [15:0] REL0      = 16'((CELL_US - LOW0_US) * CLK_PER_US);
    localparam logic [15:0] REL1      = 16'((CELL_US - LOW1_US) * CLK_PER_US);

    logic [15:0] cnt;
    logic [15:0] rel;
    logic        active;

    assign done = active && (cnt == 16'd0);

    // cnt counts remaining cycles; the line stays low while more than rel remain
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            cnt      <= '0;
            rel      <= '0;
            active   <= 1'b0;
            line_low <= 1'b0;
        end else if (start) begin
            active   <= 1'b1;
            line_low <= 1'b1;
            cnt      <= is_stop ? STOP_LAST : CELL_LAST;
            rel      <= is_stop ? 16'd0 : (bit_val ? REL1 : REL0);
        end else if (active) begin
            line_low <= (cnt > rel);
            if (cnt == 16'd0) begin
                active <= 1'b0;
            end else begin
                cnt <= cnt - 16'd1;
            end
        end else begin
            line_low <= 1'b0;
        end
    end

endmodule

// File: rtl/gc_poll_tx.sv
// GameCube poll transmitter: APB3 registers, poll period timer and the frame FSM.
// States: IDLE wait for trigger/period | SEND 24 cells | STOP 1 us low | LISTEN ready window
module gc_poll_tx
    import gc_pkg::*;
#(
    parameter int CLK_PER_US = 100,
    parameter int LISTEN_US  = 300
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        data_oe,
    output logic        ready,
    output logic        busy
);

    localparam logic [15:0] LISTEN_LAST = 16'(LISTEN_US * CLK_PER_US - 1);
    localparam logic [15:0] US_LAST     = 16'(CLK_PER_US - 1);
    // Reload one short so the cycle of the start decision counts as elapsed time
    localparam logic [15:0] US_RELOAD   = 16'(CLK_PER_US - 2);

    gc_state_e   state, state_nx;
    logic        enable, rumble, trig_pend;
    logic [15:0] period;
    logic [7:0]  poll_count;
    logic [23:0] shift_q;
    logic [4:0]  bit_cnt;
    logic [15:0] listen_cnt;
    logic [15:0] us_div;
    logic [15:0] elapsed;
    logic [23:0] cmd_now;
    logic        wr, wr_ctrl, wr_period, expired;
    logic        frame_start, bit_start, bit_val, bit_stop, bit_done;
    logic        unused_bits;

    assign PREADY      = 1'b1;
    assign PSLVERR     = 1'b0;
    assign unused_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

    assign wr        = PSEL && PENABLE && PWRITE;
    assign wr_ctrl   = wr && (PADDR[3:2] == ADDR_CTRL[3:2]);
    assign wr_period = wr && (PADDR[3:2] == ADDR_PERIOD[3:2]);
    assign expired   = (elapsed >= period);
    assign cmd_now   = POLL_CMD | {23'd0, rumble};

    always_comb begin
        PRDATA = '0;
        case (PADDR[3:2])
            ADDR_CTRL[3:2]:   PRDATA[1:0]  = {rumble, enable};
            ADDR_PERIOD[3:2]: PRDATA[15:0] = period;
            ADDR_STATUS[3:2]: PRDATA[15:0] = {poll_count, 6'd0, ready, busy};
            default:          PRDATA       = '0;
        endcase
    end

    always_comb begin
        state_nx    = state;
        frame_start = 1'b0;
        bit_start   = 1'b0;
        bit_val     = 1'b0;
        bit_stop    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig_pend || (enable && expired)) begin
                    frame_start = 1'b1;
                    bit_start   = 1'b1;
                    bit_val     = cmd_now[23];
                    state_nx    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (bit_done) begin
                    bit_start = 1'b1;
                    if (bit_cnt == 5'd0) begin
                        bit_stop = 1'b1;
                        state_nx = ST_STOP;
                    end else begin
                        bit_val = shift_q[23];
                    end
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_nx = ST_LISTEN;
                end
            end
            ST_LISTEN: begin
                if (listen_cnt == 16'd0) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state      <= ST_IDLE;
            enable     <= 1'b0;
            rumble     <= 1'b0;
            trig_pend  <= 1'b0;
            period     <= PERIOD_RST;
            poll_count <= '0;
            shift_q    <= '0;
            bit_cnt    <= '0;
            listen_cnt <= '0;
            us_div     <= '0;
            elapsed    <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state <= state_nx;
            ready <= (state_nx == ST_LISTEN);
            busy  <= (state_nx != ST_IDLE);

            if (wr_ctrl) begin
                enable <= PWDATA[0];
                rumble <= PWDATA[1];
            end
            if (wr_period) begin
                period <= PWDATA[15:0];
            end
            // A trigger written in the same cycle a frame starts stays pending
            if (wr_ctrl && PWDATA[2]) begin
                trig_pend <= 1'b1;
            end else if (frame_start) begin
                trig_pend <= 1'b0;
            end

            if (frame_start) begin
                us_div  <= US_RELOAD;
                elapsed <= '0;
            end else if (us_div == 16'd0) begin
                us_div <= US_LAST;
                if (elapsed != 16'hFFFF) begin
                    elapsed <= elapsed + 16'd1;
                end
            end else begin
                us_div <= us_div - 16'd1;
            end

            if (frame_start) begin
                shift_q <= {cmd_now[22:0], 1'b0};
                bit_cnt <= 5'd23;
            end else if ((state == ST_SEND) && bit_done && (bit_cnt != 5'd0)) begin
                shift_q <= {shift_q[22:0], 1'b0};
                bit_cnt <= bit_cnt - 5'd1;
            end

            if ((state == ST_STOP) && bit_done) begin
                listen_cnt <= LISTEN_LAST;
            end else if ((state == ST_LISTEN) && (listen_cnt != 16'd0)) begin
                listen_cnt <= listen_cnt - 16'd1;
            end

            if ((state == ST_LISTEN) && (listen_cnt == 16'd0)) begin
                poll_count <= poll_count + 8'd1;
            end
        end
    end

    gc_bit_tx #(
        .CLK_PER_US(CLK_PER_US)
    ) u_bit_tx (
        .PCLK     (PCLK),
        .PRESERN  (PRESERN),
        .start    (bit_start),
        .bit_val  (bit_val),
        .is_stop  (bit_stop),
        .line_low (data_oe),
        .done     (bit_done)
    );

endmodule

// File: tb/tb_gc_poll_tx.sv
// Directed bench for gc_poll_tx, run with 4 clocks/us and a 20 us listen window
// so a frame is 97*4 + 80 = 468 busy cycles.
module tb_gc_poll_tx;

    logic        PCLK;
    logic        PRESERN;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        data_oe, ready, busy;

    int tests = 0;
    int fails = 0;

    logic [23:0] cap_word;
    int          cap_lows [24];
    int          cap_stop;
    int          cap_rdy;
    logic [31:0] rd;
    int          n, idle, cnt;

    gc_poll_tx #(
        .CLK_PER_US(4),
        .LISTEN_US (20)
    ) dut (
        .PCLK    (PCLK),
        .PRESERN (PRESERN),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .data_oe (data_oe),
        .ready   (ready),
        .busy    (busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Starts on the first frame cycle; samples once per negedge.
    task automatic capture_frame();
        int lows;
        cap_word = '0;
        for (int i = 0; i < 24; i++) begin
            lows = 0;
            for (int j = 0; j < 16; j++) begin
                if (data_oe) lows++;
                @(negedge PCLK);
            end
            cap_lows[i] = lows;
            cap_word = {cap_word[22:0], (lows <= 8) ? 1'b1 : 1'b0};
        end
        cap_stop = 0;
        for (int j = 0; j < 4; j++) begin
            if (data_oe && !ready) cap_stop++;
            @(negedge PCLK);
        end
        cap_rdy = 0;
        while (ready && !data_oe && cap_rdy < 1000) begin
            cap_rdy++;
            @(negedge PCLK);
        end
    endtask

    task automatic wait_busy_rise(input int budget, output int total, output int idle_cyc);
        total = 0;
        idle_cyc = 0;
        while (busy && total < budget) begin
            total++;
            @(negedge PCLK);
        end
        while (!busy && total < budget) begin
            total++;
            idle_cyc++;
            @(negedge PCLK);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (busy && k < budget) begin
            k++;
            @(negedge PCLK);
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;

        repeat (3) @(negedge PCLK);
        check("rst_data_oe", {31'd0, data_oe}, 32'd0);
        check("rst_ready",   {31'd0, ready},   32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        PRESERN = 1'b1;
        @(negedge PCLK);
        apb_read(32'h8, rd); check("rst_status", rd, 32'h0);
        apb_read(32'h4, rd); check("rst_period", rd, 32'd16667);
        apb_read(32'h0, rd); check("rst_ctrl",   rd, 32'h0);
        apb_read(32'hC, rd); check("rsvd_read",  rd, 32'h0);
        check("pready",  {31'd0, PREADY},  32'd1);
        check("pslverr", {31'd0, PSLVERR}, 32'd0);

        // Single trigger, rumble off
        apb_write(32'h0, 32'h4);
        check("trig_t_oe",   {31'd0, data_oe}, 32'd0);
        check("trig_t_busy", {31'd0, busy},    32'd0);
        @(negedge PCLK);
        check("trig_t1_oe",   {31'd0, data_oe}, 32'd1);
        check("trig_t1_busy", {31'd0, busy},    32'd1);
        capture_frame();
        check("f1_bit0_low", cap_lows[0], 32'd12);
        check("f1_bit1_low", cap_lows[1], 32'd4);
        check("f1_word",     {8'd0, cap_word}, 32'h400302);
        check("f1_stop",     cap_stop, 32'd4);
        check("f1_ready",    cap_rdy, 32'd80);
        check("f1_busy_end", {31'd0, busy}, 32'd0);
        apb_read(32'h8, rd); check("f1_status", rd, 32'h0100);

        // Rumble frame
        apb_write(32'h0, 32'h6);
        @(negedge PCLK);
        capture_frame();
        check("f2_bit23_low", cap_lows[23], 32'd4);
        check("f2_word",      {8'd0, cap_word}, 32'h400303);
        check("f2_ready",     cap_rdy, 32'd80);
        apb_read(32'h8, rd); check("f2_status", rd, 32'h0200);

        // Rumble set mid-SEND must not alter the frame in flight
        apb_write(32'h0, 32'h4);
        apb_write(32'h0, 32'h2);
        repeat (367) @(negedge PCLK);
        cnt = 0;
        for (int j = 0; j < 16; j++) begin
            if (data_oe) cnt++;
            @(negedge PCLK);
        end
        check("f3_bit23_low", cnt, 32'd12);
        wait_idle(200, "f3_done");
        apb_read(32'h0, rd); check("f3_ctrl",   rd, 32'h2);
        apb_read(32'h8, rd); check("f3_status", rd, 32'h0300);

        // Trigger during LISTEN is serviced on the first IDLE cycle
        apb_write(32'h0, 32'h4);
        n = 0;
        while (!ready && n < 600) begin
            n++;
            @(negedge PCLK);
        end
        check("f4_listen_seen", {31'd0, ready}, 32'd1);
        apb_write(32'h0, 32'h4);
        n = 0;
        while (busy && n < 600) begin
            n++;
            @(negedge PCLK);
        end
        check("f4_idle_oe",    {31'd0, data_oe}, 32'd0);
        check("f4_idle_ready", {31'd0, ready},   32'd0);
        @(negedge PCLK);
        check("f5_start_busy", {31'd0, busy},    32'd1);
        check("f5_start_oe",   {31'd0, data_oe}, 32'd1);
        wait_idle(600, "f5_done");
        apb_read(32'h8, rd); check("f5_status", rd, 32'h0500);

        // Continuous polling, PERIOD = 200 us -> 800 cycles between starts
        apb_write(32'h4, 32'd200);
        apb_write(32'h0, 32'h1);
        wait_busy_rise(2000, n, idle);
        wait_busy_rise(2000, n, idle);
        check("cont200_spacing", n, 32'd800);
        check("cont200_idle",    idle, 32'd332);
        wait_busy_rise(2000, n, idle);
        check("cont200_spacing2", n, 32'd800);

        // PERIOD shorter than a frame -> back-to-back with one IDLE cycle
        apb_write(32'h4, 32'd50);
        wait_busy_rise(2000, n, idle);
        wait_busy_rise(2000, n, idle);
        check("cont50_spacing", n, 32'd469);
        check("cont50_idle",    idle, 32'd1);

        // Clearing enable mid-frame finishes the frame then stops
        apb_write(32'h0, 32'h0);
        check("dis_still_busy", {31'd0, busy}, 32'd1);
        wait_idle(600, "dis_frame_done");
        cnt = 0;
        for (int j = 0; j < 1000; j++) begin
            if (busy) cnt++;
            @(negedge PCLK);
        end
        check("dis_no_more", cnt, 32'd0);

        // Reset mid-SEND releases the line at once; no listen window follows
        apb_write(32'h0, 32'h4);
        repeat (50) @(negedge PCLK);
        check("mid_pre_busy", {31'd0, busy}, 32'd1);
        PRESERN = 1'b0;
        @(negedge PCLK);
        check("mid_rst_oe",    {31'd0, data_oe}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy},    32'd0);
        check("mid_rst_ready", {31'd0, ready},   32'd0);
        @(negedge PCLK);
        PRESERN = 1'b1;
        cnt = 0;
        for (int j = 0; j < 600; j++) begin
            if (ready || data_oe) cnt++;
            @(negedge PCLK);
        end
        check("mid_no_activity", cnt, 32'd0);
        apb_read(32'h4, rd); check("mid_period", rd, 32'd16667);
        apb_read(32'h8, rd); check("mid_status", rd, 32'h0);
        apb_read(32'h0, rd); check("mid_ctrl",   rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
